main_memory_pipe: RTL and testbench
===================================

Name: main_memory_pipe

Overview:
- Word-organised backing store directly downstream of Cache_Controller; services its miss fills and write-throughs.
- Single-ported, fully pipelined: accepts one request per cycle and returns read data a fixed LATENCY cycles after issue.
- Lets the cache controller overlap a block fill by issuing consecutive word reads back-to-back.

Parameters:
- LATENCY, 4, cycles from read issue edge to data_valid high; legal range 1..8.
- ADDR_W, 16, byte-address width of addr.
- WORDS_LOG2, 15, log2 of word count; the array holds 2^WORDS_LOG2 16-bit words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- enable  input  1  request valid this cycle.
- wr  input  1  1 = write request, 0 = read request; ignored when enable=0.
- addr  input  ADDR_W  byte address; bit 0 ignored; word index = addr[WORDS_LOG2:1].
- data_in  input  16  write data; sampled when enable=1 and wr=1.
- data_out  output  16  read data; valid only while data_valid=1, otherwise 16'h0000.
- data_valid  output  1  single-cycle pulse per completed read.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous, active-high.
  - On a rising edge with rst=1: all pipeline valid bits clear. data_valid=0 and data_out=0 from the following cycle.
  - Reset does not alter array contents. Any request presented during the reset cycle is discarded.
- Request sampling:
  - A request is sampled on the rising edge where enable=1 and rst=0. This is the issue edge.
  - There is no backpressure and no stall output. Every sampled request is accepted.
- Write:
  - On the issue edge, mem[word] <= data_in.
  - A write produces no data_valid pulse.
  - Latency to visibility is 0: a read issued on any later edge returns the new value.
- Read:
  - mem[word] is captured on the issue edge into pipeline stage 0, together with valid=1.
  - The stage advances one per edge through LATENCY stages.
  - data_valid is high in the cycle following the edge LATENCY-1 edges after issue. That is, for LATENCY=4, a read issued at edge t asserts data_valid during the cycle after edge t+3, with the output registered.
- Pipelining and ordering:
  - Back-to-back reads on consecutive cycles produce consecutive data_valid cycles, in issue order.
  - The number of reads in flight is unbounded up to LATENCY.
- Read/write ordering:
  - Read then write to the same word on the next edge: the read returns the old value, because it was captured at its own issue edge.
  - Write then read to the same word on the next edge: the read returns the new value.
- Idle: with enable=0, no new stage entry is made; bubbles propagate, and data_valid is low for the corresponding cycles.
- Reset mid-operation:
  - All in-flight reads are dropped; no data_valid appears for them after reset.
  - A read issued on the first edge after rst drops completes normally, LATENCY cycles later.
- Address handling:
  - The address wraps modulo 2^WORDS_LOG2 words; upper bits above WORDS_LOG2 are ignored.
  - Odd byte addresses alias the even word.
- Simultaneous events: rst=1 with enable=1 — reset wins, and neither the write nor the read takes effect.
- Uninitialised words read as 16'h0000. The array is zero-initialised at simulation start, not on reset.

Test Plan:
- Write addr=16'h1234, data_in=16'h5678, then read 16'h1234 after two idle cycles -> data_valid high exactly 4 cycles after read issue, data_out=16'h5678; data_out=0 in all other cycles.
- Back-to-back reads of 16'h0000, 16'h0002, 16'h0004, 16'h0006, pre-written with 16'h1111, 16'h2222, 16'h3333, 16'h4444 -> four consecutive data_valid cycles, in that order, first one 4 cycles after first issue.
- Read 16'hAAAA (holding 16'h0001), then on the next edge write 16'hAAAA=16'hBBBB, then read again -> first read returns 16'h0001, second returns 16'hBBBB; the write causes no valid pulse.
- Issue 3 reads, assert rst for 1 cycle while they are in flight -> no data_valid for them; previously written data survives, and a read after reset returns the stored value with normal latency.
- rst=1 with enable=1, wr=1, addr=16'h0010, data=16'hDEAD -> a later read of 16'h0010 returns 16'h0000.
- Odd address 16'h0011 write 16'hCAFE -> read of 16'h0010 returns 16'hCAFE; write at 16'h0010 with WORDS_LOG2 reduced to 4 aliases word 8.

Source files
------------

// File: rtl/main_memory_pipe_if.sv
// Request/response bundle between the cache controller (master) and the
// pipelined main memory (slave).
interface main_memory_pipe_if #(
  parameter int ADDR_W = 16
);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data_in;
  logic [15:0]       data_out;
  logic              data_valid;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid
  );
endinterface

// File: rtl/main_memory_pipe.sv
// Single-ported word memory with a fixed-latency read pipeline; one request
// per cycle, writes visible to any later read, reads returned in issue order.
module main_memory_pipe #(
  parameter int LATENCY    = 4,
  parameter int ADDR_W     = 16,
  parameter int WORDS_LOG2 = 15
) (
  input  logic              clk,
  input  logic              rst,
  main_memory_pipe_if.slave bus
);
  localparam int DEPTH = 2 ** WORDS_LOG2;

  // Power-up contents are zero; reset deliberately leaves the array alone.
  logic [15:0] mem [DEPTH] = '{default: 16'h0000};

  logic [WORDS_LOG2-1:0] word_idx;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [15:0]           ram_q_reg;
  logic                  rd_valid_reg;

  logic                  stage_valid [LATENCY];
  logic [15:0]           stage_data  [LATENCY];

  logic                  unused_addr_bits;

  // Byte address: bit 0 and anything above the word index are don't-care.
  assign word_idx         = bus.addr[WORDS_LOG2:1];
  assign unused_addr_bits = ^bus.addr;

  assign wr_fire = !rst && bus.enable && bus.wr;
  assign rd_fire = !rst && bus.enable && !bus.wr;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[word_idx] <= bus.data_in;
    end
  end

  // Registered array read forms pipeline stage 0.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      ram_q_reg <= mem[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
    end
  end

  assign stage_valid[0] = rd_valid_reg;
  assign stage_data[0]  = ram_q_reg;

  // Only the valid bits are reset; the data path is a plain shift register.
  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
      logic        valid_reg;
      logic [15:0] data_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= stage_valid[gi-1];
        end
        data_reg <= stage_data[gi-1];
      end

      assign stage_valid[gi] = valid_reg;
      assign stage_data[gi]  = data_reg;
    end
  endgenerate

  assign bus.data_valid = stage_valid[LATENCY-1];
  assign bus.data_out   = stage_valid[LATENCY-1] ? stage_data[LATENCY-1] : 16'h0000;
endmodule

// File: tb/tb_main_memory_pipe.sv
// Randomised and directed checks of main_memory_pipe against a queue/array
// reference model of the read latency and memory contents.
module tb_main_memory_pipe;
  localparam int LAT = 4;
  localparam int WL2 = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  main_memory_pipe_if #(.ADDR_W(16)) bus ();
  main_memory_pipe_if #(.ADDR_W(16)) sbus ();

  main_memory_pipe #(.LATENCY(LAT), .ADDR_W(16), .WORDS_LOG2(WL2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  main_memory_pipe #(.LATENCY(LAT), .ADDR_W(16), .WORDS_LOG2(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_model [int];
  logic [15:0] smem [16];
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;

  function automatic logic [15:0] model_read(input int w);
    if (mem_model.exists(w)) return mem_model[w];
    return 16'h0000;
  endfunction

  // One request per call, presented at the negedge before its issue edge.
  task automatic cycle(input logic r, input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    int word;
    @(negedge clk);
    rst = r;
    bus.enable = en;
    bus.wr = w;
    bus.addr = a;
    bus.data_in = d;
    word = (int'(a) >> 1) & ((1 << WL2) - 1);
    if (r) begin
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].due > cyc) exp_q.delete(i);
    end else if (en) begin
      if (w) mem_model[word] = d;
      else exp_q.push_back('{cyc + LAT, model_read(word)});
    end
    if (r || en)
      $display("txn cyc=%0d rst=%b en=%b wr=%b addr=%h data=%h", cyc, r, en, w, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Continuous output monitor against the expected-read queue.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus.data_valid === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          errors++;
          $display("FAIL unexpected_valid cyc=%0d data_out=%h, required no pulse", cyc, bus.data_out);
        end else begin
          if (bus.data_out !== exp_q[0].data) begin
            errors++;
            $display("FAIL read_data cyc=%0d got=%h exp=%h", cyc, bus.data_out, exp_q[0].data);
          end else begin
            $display("read done cyc=%0d data=%h", cyc, bus.data_out);
          end
          void'(exp_q.pop_front());
        end
      end else begin
        if (bus.data_valid !== 1'b0 || bus.data_out !== 16'h0000) begin
          errors++;
          $display("FAIL idle_outputs cyc=%0d valid=%b data_out=%h, required 0/0000",
                   cyc, bus.data_valid, bus.data_out);
        end
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          errors++;
          $display("FAIL missing_valid cyc=%0d got valid=%b exp data=%h", cyc, bus.data_valid, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checks += 2;
    if (bus.data_valid !== 1'b0 || bus.data_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_main got valid=%b data=%h exp 0/0000", bus.data_valid, bus.data_out);
    end
    if (sbus.data_valid !== 1'b0 || sbus.data_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_small got valid=%b data=%h exp 0/0000", sbus.data_valid, sbus.data_out);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    cycle(1'b0, 1'b1, 1'b1, 16'h1234, 16'h5678);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000);
    idle(LAT + 2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 1'b1, 16'(2 * i), 16'(16'h1111 * (i + 1)));
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 1'b0, 16'(2 * i), 16'h0000);
    idle(LAT + 2);
  endtask

  task automatic test_read_write_order();
    cycle(1'b0, 1'b1, 1'b1, 16'hAAAA, 16'h0001);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h0000);
    cycle(1'b0, 1'b1, 1'b1, 16'hAAAA, 16'hBBBB);
    cycle(1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h0000);
    idle(LAT + 2);
  endtask

  task automatic test_reset_inflight();
    cycle(1'b0, 1'b1, 1'b1, 16'h0100, 16'h7777);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    idle(LAT + 2);
  endtask

  task automatic test_reset_with_write();
    cycle(1'b1, 1'b1, 1'b1, 16'h0010, 16'hDEAD);
    cycle(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(LAT + 2);
  endtask

  task automatic test_odd_alias();
    cycle(1'b0, 1'b1, 1'b1, 16'h0011, 16'hCAFE);
    cycle(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000);
    idle(LAT + 2);
  endtask

  task automatic small_txn(input logic w, input logic [15:0] a, input logic [15:0] d);
    int          word;
    logic [15:0] expv;
    @(negedge clk);
    sbus.enable = 1'b1;
    sbus.wr = w;
    sbus.addr = a;
    sbus.data_in = d;
    word = (int'(a) >> 1) & 15;
    expv = smem[word];
    if (w) smem[word] = d;
    $display("txn small wr=%b addr=%h data=%h", w, a, d);
    @(negedge clk);
    sbus.enable = 1'b0;
    if (w) begin
      checks++;
      if (sbus.data_valid !== 1'b0) begin
        errors++;
        $display("FAIL small_write_pulse got valid=%b exp 0", sbus.data_valid);
      end
    end else begin
      repeat (LAT - 1) @(negedge clk);
      checks++;
      if (sbus.data_valid !== 1'b1 || sbus.data_out !== expv) begin
        errors++;
        $display("FAIL small_alias addr=%h got valid=%b data=%h exp 1/%h", a, sbus.data_valid, sbus.data_out, expv);
      end
    end
  endtask

  task automatic test_small_alias();
    idle(1);
    for (int i = 0; i < 16; i++) smem[i] = 16'h0000;
    small_txn(1'b1, 16'h0010, 16'h5A5A);
    small_txn(1'b0, 16'h0030, 16'h0000);
    small_txn(1'b0, 16'h0010, 16'h0000);
    small_txn(1'b1, 16'h0020, 16'h1357);
    small_txn(1'b0, 16'h0000, 16'h0000);
    small_txn(1'b0, 16'hFFF1, 16'h0000);
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic        r, en, w;
      logic [15:0] a, d;
      r  = ($urandom_range(0, 39) == 0);
      en = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      a  = 16'h4000 + 16'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a[15] = 1'b1;
      d  = 16'($urandom);
      cycle(r, en, w, a, d);
    end
    idle(LAT + 2);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.data_in = '0;
    sbus.enable = 1'b0;
    sbus.wr = 1'b0;
    sbus.addr = '0;
    sbus.data_in = '0;

    test_reset();
    test_basic();
    test_back_to_back();
    test_read_write_order();
    test_reset_inflight();
    test_reset_with_write();
    test_odd_alias();
    test_small_alias();
    test_random();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d reads outstanding exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
